game_timer: RTL and testbench
=============================

GAME_TIMER -- requirements
Module: game_timer

Interface
REQ-001 Parameter CLKS_PER_MS, default 50000, clk cycles per millisecond; legal range 2..2^20.
REQ-002 Parameter MAX_MS, default 2047, count ceiling; legal range 1..2047.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high; clears all state; driven by the game FSM reset output ORed with system reset.
REQ-005 up  input  1  count direction: 1 = up, 0 = down.
REQ-006 enable  input  1  1 = run the prescaler and counter; 0 = freeze.
REQ-007 load  input  1  one-cycle strobe that presets the counter.
REQ-008 load_value  input  11  preset value sampled when load=1.
REQ-009 timer_value  output  11  current millisecond count, registered.
REQ-010 ms_tick  output  1  one-cycle pulse on each counter update event, registered.
REQ-011 at_limit  output  1  level: (up && timer_value==MAX_MS) || (!up && timer_value==0).
REQ-012 expired  output  1  one-cycle pulse when a tick moves timer_value onto the limit, registered.

Function
REQ-013 The internal prescaler SHALL be a ceil(log2(CLKS_PER_MS))-bit counter, 0..CLKS_PER_MS-1.
REQ-014 The FSM SHALL have states IDLE, RUN and SAT; reset SHALL enter IDLE.
REQ-015 IDLE->RUN when enable=1 and at_limit=0; IDLE->SAT when enable=1 and at_limit=1.
REQ-016 RUN->IDLE when enable=0; RUN->SAT on the tick that reaches the limit.
REQ-017 SAT->RUN when at_limit deasserts (direction change or load); SAT->IDLE when enable=0.
REQ-018 In RUN with enable=1, the prescaler SHALL increment each cycle; at CLKS_PER_MS-1 it SHALL wrap to 0 on the next edge, and that edge is a tick.
REQ-019 On a tick, timer_value SHALL update on the same edge (up: +1, down: -1) and ms_tick SHALL be 1 for exactly that following cycle.
REQ-020 Tick period SHALL be exactly CLKS_PER_MS cycles under continuous enable.
REQ-021 Saturation: up at MAX_MS, or down at 0, SHALL hold timer_value; no wrap-around ever.
REQ-022 In SAT, the prescaler SHALL keep cycling and ms_tick SHALL still pulse, with timer_value held and expired=0.
REQ-023 expired SHALL pulse only on the tick whose update makes timer_value equal the limit; a held limit SHALL NOT re-pulse.
REQ-024 enable=0 SHALL freeze the prescaler and timer_value and suppress ms_tick and expired; re-enabling SHALL resume from the frozen prescaler value.
REQ-025 A change of up mid-period SHALL NOT clear the prescaler; the next tick uses the new direction.
REQ-026 load=1 SHALL set timer_value to min(load_value, MAX_MS), clear the prescaler, and suppress ms_tick and expired that cycle, regardless of enable.
REQ-027 Priority SHALL be reset > load > tick > hold.
REQ-028 at_limit SHALL be combinational from the registered timer_value and the live up input.
REQ-029 All counter arithmetic SHALL be 11-bit unsigned, with the limit compare performed before increment or decrement.

Reset
REQ-030 On reset=1 at an edge: timer_value=0, prescaler=0, ms_tick=0, expired=0, state=IDLE.
REQ-031 After reset, at_limit SHALL be 1 when up=0 and 0 when up=1.
REQ-032 Reset mid-period or mid-load SHALL discard all progress; the first tick after release SHALL occur exactly CLKS_PER_MS enabled cycles later.
REQ-033 Reset held high SHALL keep all outputs at reset values irrespective of enable, load and up.

Verification (CLKS_PER_MS=4, MAX_MS=7)
REQ-034 Reset, then up=1, enable=1 for 12 cycles -> ms_tick at cycles 4, 8 and 12; timer_value 1, 2, 3; expired=0.
REQ-035 Count up until timer_value=7 -> expired pulses once on the 6->7 tick; further ticks keep the value at 7 with ms_tick pulsing and expired=0; at_limit=1.
REQ-036 load_value=5, load=1, up=0, enable=1 -> timer_value=5 next cycle; ticks give 4, 3, 2, 1, 0; expired on the 1->0 tick only; no underflow.
REQ-037 load_value=2000 with load=1 -> timer_value=7; load together with a tick edge -> timer_value=load value, ms_tick=0.
REQ-038 enable=0 for 10 cycles at prescaler=2 -> no change; after re-enable, the tick arrives after 2 cycles.
REQ-039 reset asserted at prescaler=3 with timer_value=4 -> all outputs 0; the next tick comes 4 enabled cycles after release.

Source files
------------

// File: rtl/game_timer_if.sv
`default_nettype none
// ============================================================================
//  Module      : game_timer_if
//  Description : Control/status bundle between the game logic and the
//                millisecond game timer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface game_timer_if;
  logic        up;           // 1 = count up, 0 = count down
  logic        enable;       // run prescaler and counter
  logic        load;         // one-cycle preset strobe
  logic [10:0] load_value;   // preset value sampled with load
  logic [10:0] timer_value;  // current millisecond count
  logic        ms_tick;      // one-cycle pulse per counter update event
  logic        at_limit;     // counter sits on the limit for current direction
  logic        expired;      // one-cycle pulse when a tick lands on the limit

  // Game logic side: drives controls, observes the timer.
  modport master (
    output up, enable, load, load_value,
    input  timer_value, ms_tick, at_limit, expired
  );

  // Timer side.
  modport slave (
    input  up, enable, load, load_value,
    output timer_value, ms_tick, at_limit, expired
  );
endinterface
`default_nettype wire

// File: rtl/game_timer.sv
`default_nettype none
// ============================================================================
//  Module      : game_timer
//  Description : Saturating up/down millisecond counter driven by a clock
//                prescaler, with preset load, tick and expiry pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module game_timer #(
  parameter int CLKS_PER_MS = 50000,
  parameter int MAX_MS      = 2047
) (
  input  wire logic     clk,
  input  wire logic     reset,
  game_timer_if.slave   bus
);

  localparam int                  c_PRESC_W    = $clog2(CLKS_PER_MS);
  localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(CLKS_PER_MS - 1);
  localparam logic [10:0]         c_MAX        = 11'(MAX_MS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_SAT  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [c_PRESC_W-1:0] r_presc;
  logic [10:0]          r_timer;
  logic                 r_ms_tick;
  logic                 r_expired;

  logic                 w_at_limit;
  logic                 w_tick;
  logic                 w_reach;
  logic [10:0]          w_step_val;
  logic [10:0]          w_load_clamped;

  // Limit detection and tick/step decode; the limit compare is done on the
  // current value, before any increment or decrement is applied.
  always_comb begin
    w_at_limit     = (bus.up && (r_timer == c_MAX)) || (!bus.up && (r_timer == 11'd0));
    w_tick         = bus.enable && !bus.load && (r_presc == c_PRESC_LAST);
    w_step_val     = bus.up ? (r_timer + 11'd1) : (r_timer - 11'd1);
    w_reach        = !w_at_limit &&
                     (bus.up ? (r_timer == (c_MAX - 11'd1)) : (r_timer == 11'd1));
    w_load_clamped = (bus.load_value > c_MAX) ? c_MAX : bus.load_value;
  end

  // Prescaler, counter and registered pulses: reset > load > tick > hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc   <= '0;
      r_timer   <= 11'd0;
      r_ms_tick <= 1'b0;
      r_expired <= 1'b0;
    end else if (bus.load) begin
      r_presc   <= '0;
      r_timer   <= w_load_clamped;
      r_ms_tick <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_ms_tick <= w_tick;
      r_expired <= w_tick && w_reach;
      if (bus.enable) begin
        r_presc <= (r_presc == c_PRESC_LAST) ? '0 : (r_presc + c_PRESC_W'(1));
      end
      // A held limit never wraps: the step is taken only off the limit.
      if (w_tick && !w_at_limit) begin
        r_timer <= w_step_val;
      end
    end
  end

  // Run-state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Run-state transitions: idle when frozen, saturated while on the limit.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.enable) begin
          w_state_next = w_at_limit ? S_SAT : S_RUN;
        end
      end
      S_RUN: begin
        if (!bus.enable) begin
          w_state_next = S_IDLE;
        end else if (w_tick && w_reach) begin
          w_state_next = S_SAT;
        end
      end
      S_SAT: begin
        if (!bus.enable) begin
          w_state_next = S_IDLE;
        end else if (!w_at_limit) begin
          w_state_next = S_RUN;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign bus.timer_value = r_timer;
  assign bus.ms_tick     = r_ms_tick;
  assign bus.expired     = r_expired;
  assign bus.at_limit    = w_at_limit;

endmodule
`default_nettype wire

// File: tb/tb_game_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_game_timer
//  Description : Randomized and directed self-checking bench for game_timer
//                against a millisecond-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_game_timer;

  localparam int c_CPM = 4;
  localparam int c_MAX = 7;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  // Reference model state: elapsed enabled cycles within the current
  // millisecond, the millisecond count and the pulses of the last edge.
  int   m_val;
  int   m_phase;
  bit   m_tick;
  bit   m_exp;

  game_timer_if bus ();

  game_timer #(
    .CLKS_PER_MS (c_CPM),
    .MAX_MS      (c_MAX)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit u, input bit en, input bit ld,
                            input int lv);
    int old;
    if (r) begin
      m_val = 0; m_phase = 0; m_tick = 0; m_exp = 0;
    end else if (ld) begin
      m_val = (lv > c_MAX) ? c_MAX : lv;
      m_phase = 0; m_tick = 0; m_exp = 0;
    end else if (en) begin
      m_phase = (m_phase + 1) % c_CPM;
      m_tick  = (m_phase == 0);
      m_exp   = 0;
      if (m_tick) begin
        old = m_val;
        if (u && m_val < c_MAX) m_val = m_val + 1;
        else if (!u && m_val > 0) m_val = m_val - 1;
        m_exp = (m_val != old) && (u ? (m_val == c_MAX) : (m_val == 0));
      end
    end else begin
      m_tick = 0; m_exp = 0;
    end
  endtask

  // One clock: drive inputs on the falling edge, advance the model at the
  // rising edge and compare all outputs shortly after it.
  task automatic step(input bit r, input bit u, input bit en, input bit ld,
                      input logic [10:0] lv);
    @(negedge clk);
    reset          = r;
    bus.up         = u;
    bus.enable     = en;
    bus.load       = ld;
    bus.load_value = lv;
    @(posedge clk);
    model_edge(r, u, en, ld, int'(lv));
    #1;
    chk("timer_value", 32'(bus.timer_value), 32'(m_val));
    chk("ms_tick",     32'(bus.ms_tick),     32'(m_tick));
    chk("expired",     32'(bus.expired),     32'(m_exp));
    chk("at_limit",    32'(bus.at_limit),
        32'(u ? (m_val == c_MAX) : (m_val == 0)));
  endtask

  initial begin
    bit u;
    n_checks = 0;
    n_errors = 0;
    m_val = 0; m_phase = 0; m_tick = 0; m_exp = 0;
    reset = 1'b1;
    bus.up = 1'b0; bus.enable = 1'b0; bus.load = 1'b0; bus.load_value = '0;

    // Reset held: outputs stay at reset values whatever the controls do.
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 11'($urandom));
    step(1'b1, 1'b0, 1'b0, 1'b0, 11'd0);

    // Count up through the limit: ticks every 4 cycles, expiry on 6->7 only.
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 11'd0);

    // Load 5 and count down to 0 without underflow.
    step(1'b0, 1'b0, 1'b1, 1'b1, 11'd5);
    for (int i = 0; i < 28; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 11'd0);

    // Over-range load clamps; a load on a would-be tick edge wins.
    step(1'b0, 1'b1, 1'b1, 1'b1, 11'd2000);
    step(1'b0, 1'b0, 1'b1, 1'b0, 11'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 11'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 11'd0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 11'd3);

    // Freeze at prescaler 2 for 10 cycles, then resume.
    step(1'b0, 1'b1, 1'b1, 1'b0, 11'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 11'd0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 11'd0);
    for (int i = 0; i < 3; i++)  step(1'b0, 1'b1, 1'b1, 1'b0, 11'd0);

    // Reset at prescaler 3 with value 4, then first tick 4 cycles later.
    step(1'b0, 1'b1, 1'b1, 1'b1, 11'd4);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 11'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 11'd0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 11'd0);

    // Randomized traffic: rare resets, occasional loads, direction flips.
    u = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) u = ~u;
      step(($urandom_range(0, 149) == 0),
           u,
           ($urandom_range(0, 9) < 8),
           ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 3) == 0) ? 11'($urandom) : 11'($urandom_range(0, 9)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
